// File: rtl/mul32_seq.sv
// ============================================================================
// Module   : mul32_seq (with adder32)
// Brief    : Unsigned 32x32->64 shift-add multiplier on one adder32 instance.
//            Optional macro MUL32_ZERO_SKIP_EN makes zero operands finish at once.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        C0,
    output logic [31:0] S,
    output logic        C32
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_carry;
    logic [7:0]  w_grp_g;
    logic [7:0]  w_grp_p;
    logic [8:0]  w_grp_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // 4-bit lookahead blocks: group generate/propagate plus in-group carries
    for (genvar j = 0; j < 8; j++) begin : g_grp
        logic [3:0] w_gg;
        logic [3:0] w_pp;
        logic       w_ci;
        assign w_gg = w_g[4*j +: 4];
        assign w_pp = w_p[4*j +: 4];
        assign w_ci = w_grp_c[j];

        assign w_grp_g[j] = w_gg[3]
                          | (w_pp[3] & w_gg[2])
                          | (w_pp[3] & w_pp[2] & w_gg[1])
                          | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]);
        assign w_grp_p[j] = &w_pp;

        assign w_carry[4*j]     = w_ci;
        assign w_carry[4*j + 1] = w_gg[0] | (w_pp[0] & w_ci);
        assign w_carry[4*j + 2] = w_gg[1] | (w_pp[1] & w_gg[0])
                                | (w_pp[1] & w_pp[0] & w_ci);
        assign w_carry[4*j + 3] = w_gg[2] | (w_pp[2] & w_gg[1])
                                | (w_pp[2] & w_pp[1] & w_gg[0])
                                | (w_pp[2] & w_pp[1] & w_pp[0] & w_ci);
    end

    always_comb begin
        w_grp_c    = '0;
        w_grp_c[0] = C0;
        for (int j = 0; j < 8; j++) begin
            w_grp_c[j+1] = w_grp_g[j] | (w_grp_p[j] & w_grp_c[j]);
        end
    end

    assign S   = w_p ^ w_carry;
    assign C32 = w_grp_c[8];

endmodule

module mul32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [63:0] P
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_m;
    logic [31:0] r_h;
    logic [31:0] r_q;
    logic [5:0]  r_cnt;
    logic [63:0] r_p;

    logic [31:0] w_addend;
    logic [31:0] w_sum;
    logic        w_c32;
    logic        w_accept;
    logic        w_last;
    logic        w_zero;

    assign w_addend = r_q[0] ? r_m : 32'd0;

    adder32 u_adder (
        .A   (r_h),
        .B   (w_addend),
        .C0  (1'b0),
        .S   (w_sum),
        .C32 (w_c32)
    );

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_BUSY) && (r_cnt == 6'd31);

`ifdef MUL32_ZERO_SKIP_EN
    assign w_zero = (A == 32'd0) || (B == 32'd0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = w_zero ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (start) w_next = w_zero ? S_DONE : S_BUSY;
                else       w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // {H,Q} shifts right each iteration with the adder carry entering at the top
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_h   <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_m   <= A;
            r_q   <= B;
            r_h   <= '0;
            r_cnt <= '0;
            if (w_zero) r_p <= '0;
        end else if (r_state == S_BUSY) begin
            {r_h, r_q} <= {w_c32, w_sum, r_q[31:1]};
            r_cnt      <= r_cnt + 6'd1;
            if (w_last) r_p <= {w_c32, w_sum, r_q[31:1]};
        end
    end

    assign busy = (r_state == S_BUSY);
    assign done = (r_state == S_DONE);
    assign P    = r_p;

endmodule

`default_nettype wire

// File: tb/tb_mul32_seq.sv
// ============================================================================
// Module   : tb_mul32_seq
// Brief    : Directed + random self-checking bench for mul32_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] P;

    int tests;
    int failed;

    mul32_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is #1 after the accepting edge with 'elapsed' cycles already spent.
    task automatic wait_done(input int elapsed, input int lat, input logic [63:0] exp,
                             input bit hold, input string tag);
        int n;
        int nbusy;
        n = elapsed;
        nbusy = elapsed;
        while (!done && n < 60) begin
            check({tag, " busy_onehot"}, 64'(busy & done), 64'd0);
            tick();
            n++;
            if (busy) nbusy++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " busy_cycles"}, 64'(nbusy - (busy ? 1 : 0)), 64'(lat - 1));
        check({tag, " P"}, P, exp);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        if (hold) begin
            tick();
            check({tag, " done_pulse"}, 64'(done), 64'd0);
            check({tag, " P_hold"}, P, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat;
        logic [63:0] exp;
        exp = 64'(a) * 64'(b);
        lat = 33;
`ifdef MUL32_ZERO_SKIP_EN
        if (a == 32'd0 || b == 32'd0) lat = 1;
`endif
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_first"}, 64'(busy), (lat == 1) ? 64'd0 : 64'd1);
        wait_done(1, lat, exp, 1'b1, tag);
    endtask

    initial begin
        int zlat;
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        A      = '0;
        B      = '0;

        tick();
        tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset P", P, 64'd0);
        rst = 1'b0;
        tick();

        run_op(32'd3, 32'd5, "3x5");
        check("3x5 value", P, 64'h0000_0000_0000_000F);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
        check("max value", P, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h8000_0000, 32'h0000_0002, "msb");
        check("msb value", P, 64'h0000_0001_0000_0000);

        // start pulse during BUSY must be ignored
        A = 32'd7; B = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        A = 32'hFFFF; B = 32'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(6, 33, 64'h3F, 1'b1, "ignore");

        // reset mid-operation aborts without done
        A = 32'h1234; B = 32'h10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort P", P, 64'd0);
        begin
            int seen;
            seen = 0;
            repeat (35) begin
                tick();
                if (done || busy) seen++;
            end
            check("abort quiet", 64'(seen), 64'd0);
        end
        run_op(32'd2, 32'd4, "2x4");

        // back-to-back with start held high, zero operand first
        zlat = 33;
`ifdef MUL32_ZERO_SKIP_EN
        zlat = 1;
`endif
        A = 32'd0; B = 32'd7; start = 1'b1;
        tick();
        A = 32'd6; B = 32'd6;
        check("zero busy_first", 64'(busy), (zlat == 1) ? 64'd0 : 64'd1);
        wait_done(1, zlat, 64'd0, 1'b0, "zero");
        tick();
        start = 1'b0;
        check("b2b busy_first", 64'(busy), 64'd1);
        check("b2b P_stable", P, 64'd0);
        wait_done(1, 33, 64'd36, 1'b1, "b2b");

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i == 4) rb = 32'd0;
            if (i == 5) ra = 32'hFFFF_FFFF;
            run_op(ra, rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
